// File: rtl/pacman_defs.sv
// Shared sprite, character and FSM encodings for the pacman map/movement logic.
package pacman_defs;

  localparam int unsigned COORD_W = 5;
  localparam int unsigned SPR_W   = 3;
  localparam int unsigned CHAR_W  = 3;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned TIMER_W = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [SPR_W-1:0] SPR_EMPTY  = 3'd0;
  localparam logic [SPR_W-1:0] SPR_WALL   = 3'd1;
  localparam logic [SPR_W-1:0] SPR_PELLET = 3'd2;
  localparam logic [SPR_W-1:0] SPR_POWER  = 3'd3;
  localparam logic [SPR_W-1:0] SPR_GATE   = 3'd4;

  localparam logic [CHAR_W-1:0] CHAR_PACMAN = 3'd0;
  localparam logic [CHAR_W-1:0] CHAR_GHOST0 = 3'd1;
  localparam logic [CHAR_W-1:0] CHAR_GHOST1 = 3'd2;
  localparam logic [CHAR_W-1:0] CHAR_GHOST2 = 3'd3;
  localparam logic [CHAR_W-1:0] CHAR_GHOST3 = 3'd4;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_READ   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_DECIDE = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd5;

  // Map tile coordinate pair
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } tile_t;

  // Tiles a character may step onto; unknown codes behave as walls
  function automatic logic spr_passable(input logic [SPR_W-1:0] s);
    return (s == SPR_EMPTY) || (s == SPR_GATE) || (s == SPR_PELLET) || (s == SPR_POWER);
  endfunction

  // Tiles that pacman consumes
  function automatic logic spr_edible(input logic [SPR_W-1:0] s);
    return (s == SPR_PELLET) || (s == SPR_POWER);
  endfunction

endpackage

// File: rtl/move_resolver_if.sv
// Request/response, map port and status bundle between controllers and move_resolver.
interface move_resolver_if;
  import pacman_defs::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [CHAR_W-1:0]    char_type;
  logic [COORD_W-1:0]   target_x;
  logic [COORD_W-1:0]   target_y;
  logic [COORD_W-1:0]   map_x;
  logic [COORD_W-1:0]   map_y;
  logic                 map_readwrite;
  logic [SPR_W-1:0]     map_data_wr;
  logic [SPR_W-1:0]     map_data_rd;
  logic                 char_write;
  logic [COORD_W-1:0]   char_x_out;
  logic [COORD_W-1:0]   char_y_out;
  logic [CHAR_W-1:0]    char_type_out;
  logic                 resp_valid;
  logic                 able_to_move;
  logic                 able_to_damage;
  logic [SCORE_W-1:0]   score;

  modport slave (
    input  req_valid, char_type, target_x, target_y, map_data_rd,
    output req_ready, map_x, map_y, map_readwrite, map_data_wr,
           char_write, char_x_out, char_y_out, char_type_out,
           resp_valid, able_to_move, able_to_damage, score
  );

  modport master (
    output req_valid, char_type, target_x, target_y, map_data_rd,
    input  req_ready, map_x, map_y, map_readwrite, map_data_wr,
           char_write, char_x_out, char_y_out, char_type_out,
           resp_valid, able_to_move, able_to_damage, score
  );
endinterface

// File: rtl/power_timer.sv
// Power-pellet countdown: reload on load, decrement on tick while nonzero.
module power_timer
  import pacman_defs::*;
#(
  parameter int unsigned TICKS = 50
) (
  input  logic clock_50,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic nonzero
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] count_nx;

  // Next count: a reload always beats a coincident tick
  always_comb begin
    count_nx = count;
    if (load) begin
      count_nx = TIMER_W'(TICKS);
    end else if (tick && (count != '0)) begin
      count_nx = count - TIMER_W'(1);
    end
  end

  // Count and registered nonzero flag, kept in step with each other
  always_ff @(posedge clock_50) begin
    if (reset) begin
      count   <= '0;
      nonzero <= 1'b0;
    end else begin
      count   <= count_nx;
      nonzero <= (count_nx != '0);
    end
  end

endmodule

// File: rtl/move_resolver.sv
// Resolves movement requests against the map, eats pellets, keeps score and commits positions.
module move_resolver
  import pacman_defs::*;
#(
  parameter int unsigned MAP_W       = 32,
  parameter int unsigned MAP_H       = 24,
  parameter int unsigned POWER_TICKS = 50,
  parameter int unsigned PELLET_PTS  = 1,
  parameter int unsigned POWER_PTS   = 5
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             tick,
  move_resolver_if.slave   bus
);

  localparam logic [COORD_W:0]   MAP_W_L      = (COORD_W+1)'(MAP_W);
  localparam logic [COORD_W:0]   MAP_H_L      = (COORD_W+1)'(MAP_H);
  localparam logic [SCORE_W-1:0] PELLET_PTS_L = SCORE_W'(PELLET_PTS);
  localparam logic [SCORE_W-1:0] POWER_PTS_L  = SCORE_W'(POWER_PTS);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;

  tile_t              tgt;
  logic [CHAR_W-1:0]  char_q;
  logic [SPR_W-1:0]   spr_q;
  logic               legal_q;

  logic               req_ready_q;
  logic [COORD_W-1:0] map_x_q;
  logic [COORD_W-1:0] map_y_q;
  logic               map_readwrite_q;
  logic [SPR_W-1:0]   map_data_wr_q;
  logic               char_write_q;
  logic [COORD_W-1:0] char_x_q;
  logic [COORD_W-1:0] char_y_q;
  logic [CHAR_W-1:0]  char_type_q;
  logic               resp_valid_q;
  logic               able_to_move_q;
  logic               able_to_damage_q;
  logic [SCORE_W-1:0] score_q;

  logic               accept_c;
  logic               in_range_c;
  logic               eat_c;
  logic               power_load_c;
  logic [SCORE_W-1:0] pts_c;
  logic [SCORE_W:0]   score_sum_c;

  assign accept_c     = req_ready_q && bus.req_valid;
  assign in_range_c   = ({1'b0, bus.target_x} < MAP_W_L) && ({1'b0, bus.target_y} < MAP_H_L);
  assign eat_c        = spr_edible(bus.map_data_rd) && (char_q == CHAR_PACMAN);
  assign power_load_c = (state == ST_WRITE) && (spr_q == SPR_POWER);
  assign pts_c        = (spr_q == SPR_POWER) ? POWER_PTS_L : PELLET_PTS_L;
  assign score_sum_c  = {1'b0, score_q} + {1'b0, pts_c};

  // State register
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept_c) state_nx = in_range_c ? ST_READ : ST_RESP;
      ST_READ:   state_nx = ST_WAIT;
      ST_WAIT:   state_nx = ST_DECIDE;
      ST_DECIDE: state_nx = (spr_passable(bus.map_data_rd) && eat_c) ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Request capture, registered outputs and score; strobes default low each cycle
  always_ff @(posedge clock_50) begin
    if (reset) begin
      tgt             <= '0;
      char_q          <= '0;
      spr_q           <= '0;
      legal_q         <= 1'b0;
      req_ready_q     <= 1'b1;
      map_x_q         <= '0;
      map_y_q         <= '0;
      map_readwrite_q <= 1'b0;
      map_data_wr_q   <= '0;
      char_write_q    <= 1'b0;
      char_x_q        <= '0;
      char_y_q        <= '0;
      char_type_q     <= '0;
      resp_valid_q    <= 1'b0;
      able_to_move_q  <= 1'b0;
      score_q         <= '0;
    end else begin
      req_ready_q     <= (state_nx == ST_IDLE);
      map_readwrite_q <= 1'b0;
      char_write_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            tgt     <= '{y: bus.target_y, x: bus.target_x};
            char_q  <= bus.char_type;
            legal_q <= 1'b0;
            if (in_range_c) begin
              map_x_q <= bus.target_x;
              map_y_q <= bus.target_y;
            end
          end
        end
        ST_DECIDE: begin
          legal_q <= spr_passable(bus.map_data_rd);
          spr_q   <= bus.map_data_rd;
        end
        ST_WRITE: begin
          map_readwrite_q <= 1'b1;
          map_data_wr_q   <= SPR_EMPTY;
          score_q         <= score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
        end
        ST_RESP: begin
          resp_valid_q   <= 1'b1;
          able_to_move_q <= legal_q;
          if (legal_q) begin
            char_write_q <= 1'b1;
            char_x_q     <= tgt.x;
            char_y_q     <= tgt.y;
            char_type_q  <= char_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Power-pellet timer drives able_to_damage
  power_timer #(
    .TICKS (POWER_TICKS)
  ) u_power_timer (
    .clock_50 (clock_50),
    .reset    (reset),
    .load     (power_load_c),
    .tick     (tick),
    .nonzero  (able_to_damage_q)
  );

  assign bus.req_ready      = req_ready_q;
  assign bus.map_x          = map_x_q;
  assign bus.map_y          = map_y_q;
  assign bus.map_readwrite  = map_readwrite_q;
  assign bus.map_data_wr    = map_data_wr_q;
  assign bus.char_write     = char_write_q;
  assign bus.char_x_out     = char_x_q;
  assign bus.char_y_out     = char_y_q;
  assign bus.char_type_out  = char_type_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.able_to_move   = able_to_move_q;
  assign bus.able_to_damage = able_to_damage_q;
  assign bus.score          = score_q;

endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver with a two-cycle-latency map RAM model.
module tb_move_resolver;
  import pacman_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tick;

  move_resolver_if b ();
  move_resolver_if s ();

  move_resolver #(
    .MAP_W(30), .MAP_H(24), .POWER_TICKS(3), .PELLET_PTS(1), .POWER_PTS(5)
  ) u_dut (
    .clock_50 (clk), .reset (reset), .tick (tick), .bus (b)
  );

  move_resolver #(
    .MAP_W(32), .MAP_H(24), .POWER_TICKS(3), .PELLET_PTS(65534), .POWER_PTS(5)
  ) u_sat (
    .clock_50 (clk), .reset (reset), .tick (tick), .bus (s)
  );

  // Map RAM models: address registered, data one cycle later
  logic [2:0] mem_b [0:1023];
  logic [2:0] mem_s [0:1023];
  logic [9:0] a1_b, a1_s;
  logic [2:0] rd_b, rd_s;
  logic       poke_en, poke_sel;
  logic [9:0] poke_addr;
  logic [2:0] poke_val;

  always @(posedge clk) begin
    a1_b <= {b.map_y, b.map_x};
    rd_b <= mem_b[a1_b];
    if (b.map_readwrite) mem_b[{b.map_y, b.map_x}] <= b.map_data_wr;
    if (poke_en && !poke_sel) mem_b[poke_addr] <= poke_val;
  end

  always @(posedge clk) begin
    a1_s <= {s.map_y, s.map_x};
    rd_s <= mem_s[a1_s];
    if (s.map_readwrite) mem_s[{s.map_y, s.map_x}] <= s.map_data_wr;
    if (poke_en && poke_sel) mem_s[poke_addr] <= poke_val;
  end

  assign b.map_data_rd = rd_b;
  assign s.map_data_rd = rd_s;

  int checks   = 0;
  int failures = 0;

  int         r_lat, r_wr_lat;
  logic       r_move, r_cw, r_wr;
  logic [4:0] r_cx, r_cy, r_wr_x, r_wr_y;
  logic [2:0] r_wd;
  logic       any_rw, any_cw, any_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic sel, input logic [4:0] x, input logic [4:0] y, input logic [2:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_addr = {y, x}; poke_val = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  // Issue one request and watch up to 20 cycles for the response
  task automatic do_req(input logic sel, input logic [4:0] x, input logic [4:0] y,
                        input logic [2:0] ct, input int tick_at);
    logic rw, rv, cw, mv;
    logic [4:0] mx, my, cx, cy;
    logic [2:0] wd;
    @(negedge clk);
    if (sel) begin
      s.req_valid = 1'b1; s.target_x = x; s.target_y = y; s.char_type = ct;
    end else begin
      b.req_valid = 1'b1; b.target_x = x; b.target_y = y; b.char_type = ct;
    end
    @(posedge clk); #1;
    b.req_valid = 1'b0; s.req_valid = 1'b0;
    r_lat = 0; r_wr_lat = 0; r_move = 1'b0; r_cw = 1'b0; r_wr = 1'b0;
    r_cx = '0; r_cy = '0; r_wr_x = '0; r_wr_y = '0; r_wd = 3'd7;
    for (int cyc = 1; cyc <= 20 && r_lat == 0; cyc++) begin
      if (cyc == tick_at) tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      rw = sel ? s.map_readwrite : b.map_readwrite;
      rv = sel ? s.resp_valid    : b.resp_valid;
      cw = sel ? s.char_write    : b.char_write;
      mv = sel ? s.able_to_move  : b.able_to_move;
      mx = sel ? s.map_x         : b.map_x;
      my = sel ? s.map_y         : b.map_y;
      cx = sel ? s.char_x_out    : b.char_x_out;
      cy = sel ? s.char_y_out    : b.char_y_out;
      wd = sel ? s.map_data_wr   : b.map_data_wr;
      if (rw && !r_wr) begin
        r_wr = 1'b1; r_wr_lat = cyc; r_wr_x = mx; r_wr_y = my; r_wd = wd;
      end
      if (cw) begin
        r_cw = 1'b1; r_cx = cx; r_cy = cy;
      end
      if (rv) begin
        r_lat = cyc; r_move = mv;
      end
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    poke_en = 1'b0; poke_sel = 1'b0; poke_addr = '0; poke_val = '0;
    b.req_valid = 1'b0; b.char_type = '0; b.target_x = '0; b.target_y = '0;
    s.req_valid = 1'b0; s.char_type = '0; s.target_x = '0; s.target_y = '0;

    poke(1'b0, 5'd3,  5'd4,  SPR_EMPTY);
    poke(1'b0, 5'd3,  5'd5,  SPR_PELLET);
    poke(1'b0, 5'd5,  5'd5,  SPR_POWER);
    poke(1'b0, 5'd6,  5'd6,  SPR_WALL);
    poke(1'b0, 5'd29, 5'd23, SPR_GATE);
    poke(1'b0, 5'd7,  5'd7,  SPR_POWER);
    poke(1'b0, 5'd8,  5'd8,  SPR_POWER);
    poke(1'b0, 5'd9,  5'd9,  SPR_POWER);
    poke(1'b0, 5'd10, 5'd10, SPR_PELLET);
    poke(1'b1, 5'd1,  5'd1,  SPR_PELLET);
    poke(1'b1, 5'd2,  5'd2,  SPR_POWER);
    poke(1'b1, 5'd2,  5'd3,  SPR_POWER);

    @(posedge clk); #1;
    chk("rst_req_ready",  32'(b.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(b.resp_valid), 32'd0);
    chk("rst_score",      32'(b.score), 32'd0);
    chk("rst_move",       32'(b.able_to_move), 32'd0);
    chk("rst_damage",     32'(b.able_to_damage), 32'd0);
    chk("rst_char_write", 32'(b.char_write), 32'd0);
    chk("rst_map_rw",     32'(b.map_readwrite), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Pacman onto EMPTY
    do_req(1'b0, 5'd3, 5'd4, CHAR_PACMAN, 0);
    chk("empty_lat",  32'(r_lat), 32'd4);
    chk("empty_move", 32'(r_move), 32'd1);
    chk("empty_cw",   32'(r_cw), 32'd1);
    chk("empty_cx",   32'(r_cx), 32'd3);
    chk("empty_cy",   32'(r_cy), 32'd4);
    chk("empty_nowr", 32'(r_wr), 32'd0);

    // Pacman eats a PELLET
    do_req(1'b0, 5'd3, 5'd5, CHAR_PACMAN, 0);
    chk("pel_wr",     32'(r_wr), 32'd1);
    chk("pel_wr_lat", 32'(r_wr_lat), 32'd4);
    chk("pel_wr_x",   32'(r_wr_x), 32'd3);
    chk("pel_wr_y",   32'(r_wr_y), 32'd5);
    chk("pel_wr_d",   32'(r_wd), 32'(SPR_EMPTY));
    chk("pel_lat",    32'(r_lat), 32'd5);
    chk("pel_move",   32'(r_move), 32'd1);
    chk("pel_score",  32'(b.score), 32'd1);
    chk("pel_map",    32'(mem_b[{5'd5, 5'd3}]), 32'(SPR_EMPTY));
    do_req(1'b0, 5'd3, 5'd5, CHAR_PACMAN, 0);
    chk("pel_again_lat",  32'(r_lat), 32'd4);
    chk("pel_again_nowr", 32'(r_wr), 32'd0);

    // Ghost onto POWER: moves, nothing eaten
    do_req(1'b0, 5'd5, 5'd5, CHAR_GHOST0, 0);
    chk("gh_lat",    32'(r_lat), 32'd4);
    chk("gh_move",   32'(r_move), 32'd1);
    chk("gh_cw",     32'(r_cw), 32'd1);
    chk("gh_nowr",   32'(r_wr), 32'd0);
    chk("gh_score",  32'(b.score), 32'd1);
    chk("gh_damage", 32'(b.able_to_damage), 32'd0);
    chk("gh_map",    32'(mem_b[{5'd5, 5'd5}]), 32'(SPR_POWER));
    repeat (3) @(posedge clk); #1;
    chk("move_held", 32'(b.able_to_move), 32'd1);

    // Blocked moves
    do_req(1'b0, 5'd6, 5'd6, CHAR_PACMAN, 0);
    chk("wall_lat",  32'(r_lat), 32'd4);
    chk("wall_move", 32'(r_move), 32'd0);
    chk("wall_cw",   32'(r_cw), 32'd0);
    do_req(1'b0, 5'd31, 5'd2, CHAR_PACMAN, 0);
    chk("oorx_lat",   32'(r_lat), 32'd1);
    chk("oorx_move",  32'(r_move), 32'd0);
    chk("oorx_cw",    32'(r_cw), 32'd0);
    chk("oorx_nowr",  32'(r_wr), 32'd0);
    chk("oorx_map_x", 32'(b.map_x), 32'd6);
    do_req(1'b0, 5'd2, 5'd24, CHAR_PACMAN, 0);
    chk("oory_lat",  32'(r_lat), 32'd1);
    chk("oory_move", 32'(r_move), 32'd0);
    do_req(1'b0, 5'd29, 5'd23, CHAR_GHOST2, 0);
    chk("edge_lat",  32'(r_lat), 32'd4);
    chk("edge_move", 32'(r_move), 32'd1);

    // Power pellet and timer
    do_req(1'b0, 5'd7, 5'd7, CHAR_PACMAN, 0);
    chk("pow_lat",    32'(r_lat), 32'd5);
    chk("pow_wr",     32'(r_wr), 32'd1);
    chk("pow_score",  32'(b.score), 32'd6);
    chk("pow_damage", 32'(b.able_to_damage), 32'd1);
    pulse_tick(); pulse_tick();
    chk("pow_t2", 32'(b.able_to_damage), 32'd1);
    do_req(1'b0, 5'd8, 5'd8, CHAR_PACMAN, 0);
    chk("pow2_score", 32'(b.score), 32'd11);
    pulse_tick(); pulse_tick();
    chk("pow2_t2", 32'(b.able_to_damage), 32'd1);
    pulse_tick();
    chk("pow2_t3", 32'(b.able_to_damage), 32'd0);
    do_req(1'b0, 5'd9, 5'd9, CHAR_PACMAN, 4);
    chk("powt_lat",    32'(r_lat), 32'd5);
    chk("powt_damage", 32'(b.able_to_damage), 32'd1);
    pulse_tick(); pulse_tick();
    chk("powt_t2", 32'(b.able_to_damage), 32'd1);
    pulse_tick();
    chk("powt_t3", 32'(b.able_to_damage), 32'd0);

    // Reset while in WAIT aborts the eat
    @(negedge clk);
    b.req_valid = 1'b1; b.target_x = 5'd10; b.target_y = 5'd10; b.char_type = CHAR_PACMAN;
    @(posedge clk); #1;
    b.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready",  32'(b.req_ready), 32'd1);
    chk("abort_score",  32'(b.score), 32'd0);
    chk("abort_damage", 32'(b.able_to_damage), 32'd0);
    any_rw = 1'b0; any_cw = 1'b0; any_rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_rw |= b.map_readwrite;
      any_cw |= b.char_write;
      any_rv |= b.resp_valid;
    end
    chk("abort_nowr",   32'(any_rw), 32'd0);
    chk("abort_nocw",   32'(any_cw), 32'd0);
    chk("abort_norv",   32'(any_rv), 32'd0);
    chk("abort_map",    32'(mem_b[{5'd10, 5'd10}]), 32'(SPR_PELLET));

    // Score saturation on the second instance
    do_req(1'b1, 5'd1, 5'd1, CHAR_PACMAN, 0);
    chk("sat_pel", 32'(s.score), 32'hFFFE);
    do_req(1'b1, 5'd2, 5'd2, CHAR_PACMAN, 0);
    chk("sat_pow_lat", 32'(r_lat), 32'd5);
    chk("sat_pow",     32'(s.score), 32'hFFFF);
    do_req(1'b1, 5'd2, 5'd3, CHAR_PACMAN, 0);
    chk("sat_hold",    32'(s.score), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
